// File: rtl/seq_digit_sub_pkg.sv
// seq_digit_sub_pkg: shared FSM state encodings and digit-count helper
package seq_digit_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/seq_digit_sub_if.sv
// seq_digit_sub_if: start/done request bus carrying operands and results
interface seq_digit_sub_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, d, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, d, bout, ovf);
endinterface

// File: rtl/seq_digit_sub_fs_digit.sv
// seq_digit_sub_fs_digit: DIGIT-wide ripple full-subtractor built from half-subtractor pairs
module seq_digit_sub_fs_digit #(parameter int DIGIT = 4) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] diff,
    output logic             bo
);
    logic [DIGIT:0] br;

    assign br[0] = bi;
    assign bo    = br[DIGIT];

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        logic hd, hb1, hb2;
        assign hd        = x[i] ^ y[i];
        assign hb1       = ~x[i] & y[i];
        assign diff[i]   = hd ^ br[i];
        assign hb2       = ~hd & br[i];
        assign br[i+1]   = hb1 | hb2;
    end
endmodule

// File: rtl/seq_digit_sub.sv
// seq_digit_sub: digit-serial a - b - bin with registered borrow chain and start/done handshake
module seq_digit_sub
    import seq_digit_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic           clk,
    input logic           rst,
    seq_digit_sub_if.slave bus
);
    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r, d_r;
    logic             br, bout_r, ovf_r;
    logic [DIGIT-1:0] dd;
    logic             bo, last, accept;

    assign last   = (cnt == LAST);
    assign accept = bus.start && (state != S_RUN);

    seq_digit_sub_fs_digit #(.DIGIT(DIGIT)) u_fs_digit (
        .x    (a_r[cnt*DIGIT +: DIGIT]),
        .y    (b_r[cnt*DIGIT +: DIGIT]),
        .bi   (br),
        .diff (dd),
        .bo   (bo)
    );

    // next state: RUN until the last digit, then a one-cycle DONE that may restart
    always_comb begin
        state_n = (state == S_RUN) ? (last ? S_DONE : S_RUN) : (bus.start ? S_RUN : S_IDLE);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // operand latch on accept, then one digit per RUN cycle into the result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            br     <= 1'b0;
            d_r    <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            a_r <= bus.a;
            b_r <= bus.b;
            br  <= bus.bin;
        end else if (state == S_RUN) begin
            d_r[cnt*DIGIT +: DIGIT] <= dd;
            br  <= bo;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
                bout_r <= bo;
                ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (dd[DIGIT-1] != a_r[WIDTH-1]);
            end
        end
    end

    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_DONE);
    assign bus.d    = d_r;
    assign bus.bout = bout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_seq_digit_sub.sv
// tb_seq_digit_sub: scoreboard bench over DIGIT = 1, 2, 4, 16 instances sharing one stimulus bus
module tb_seq_digit_sub;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [W-1:0] a, b;
    logic bin;
    logic [3:0] en;

    logic [3:0]   busy_v, done_v, bout_v, ovf_v;
    logic [W-1:0] d_v [4];

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t sb [4][$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dig_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 4 : 16;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        seq_digit_sub_if #(.WIDTH(W)) bus ();
        assign bus.start = start & en[g];
        assign bus.a     = a;
        assign bus.b     = b;
        assign bus.bin   = bin;
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
        assign bout_v[g] = bus.bout;
        assign ovf_v[g]  = bus.ovf;
        assign d_v[g]    = bus.d;
        seq_digit_sub #(.WIDTH(W), .DIGIT(dig_of(g))) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // reference: plain integer arithmetic on unsigned and signed interpretations
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        int u, s;
        exp_t e;
        u = int'(av) - int'(bv) - int'(bi);
        s = int'($signed(av)) - int'($signed(bv)) - int'(bi);
        e.d = u[W-1:0];
        e.bout = (u < 0);
        e.ovf = (s > 32767) || (s < -32768);
        e.cyc = 0;
        return e;
    endfunction

    function automatic int pending();
        return sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // caller is at a negedge; start is held for one edge
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input bit push);
        exp_t e;
        start = 1'b1;
        a = av;
        b = bv;
        bin = bi;
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (en[i]) begin
                    e = model(av, bv, bi);
                    e.cyc = cyc + 1 + 16 / dig_of(i);
                    sb[i].push_back(e);
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (pending() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending want 0", pending());
            for (int i = 0; i < 4; i++) sb[i].delete();
        end
    endtask

    task automatic chk_zero(input string name);
        for (int i = 0; i < 4; i++)
            chk(name, {busy_v[i], done_v[i], bout_v[i], ovf_v[i], d_v[i]}, 32'h0);
    endtask

    // monitor: every done pulse must match the oldest expected result and its cycle
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (done_v[i]) begin
                checks++;
                if (sb[i].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: dut%0d cyc=%0d d=%h want no done", i, cyc, d_v[i]);
                end else begin
                    e = sb[i].pop_front();
                    if (d_v[i] !== e.d || bout_v[i] !== e.bout || ovf_v[i] !== e.ovf || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result dut%0d: got d=%h bout=%b ovf=%b cyc=%0d want d=%h bout=%b ovf=%b cyc=%0d",
                                 i, d_v[i], bout_v[i], ovf_v[i], cyc, e.d, e.bout, e.ovf, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int nb;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        en = 4'b0000;
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        en = 4'b0100;

        issue(16'h1234, 16'h0234, 1'b0, 1'b1);
        nb = 0;
        for (int t = 0; t < 8; t++) begin
            nb += int'(busy_v[2]);
            @(negedge clk);
        end
        chk("busy_cycles", nb, 4);
        drain();

        issue(16'h0000, 16'h0001, 1'b0, 1'b1); drain();
        issue(16'h0005, 16'h0005, 1'b1, 1'b1); drain();
        issue(16'h8000, 16'h0001, 1'b0, 1'b1); drain();
        issue(16'h7FFF, 16'hFFFF, 1'b0, 1'b1); drain();

        issue(16'h4444, 16'h1111, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        a = 16'h0003;
        b = 16'h9ABC;
        bin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (8) @(negedge clk);

        issue(16'hABCD, 16'h1234, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        issue(16'h0F0F, 16'hF0F0, 1'b0, 1'b1);
        drain();

        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_zero("reset_midrun");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_after_reset", {busy_v[2], done_v[2]}, 32'h0);

        en = 4'b1111;
        for (int n = 0; n < 1000; n++) begin
            issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'b1);
            drain();
        end
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
